// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides. One operation in
// flight: single-cycle logic/arithmetic ops, iterative shift-add multiply.
module seq_alu #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int unsigned Msb = WIDTH - 1;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 neg_q, neg_d;

  logic [WIDTH:0]       add_sum, sub_sum;
  logic                 add_ovf, sub_ovf;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic [WIDTH-1:0]     mul_lo;
  logic                 accept;

  // Held low during reset so nothing is accepted while the block is cleared.
  assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign mul_lo    = acc_q[WIDTH-1:0];

  // Single-cycle datapath evaluated on the operands presented at acceptance.
  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (a[Msb] == b[Msb]) && (add_sum[Msb] != a[Msb]);
    sub_ovf = (a[Msb] != b[Msb]) && (sub_sum[Msb] != a[Msb]);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpXor: alu_res = a ^ b;
      OpAdd: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_ovf;
      end
      OpSub: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = sub_ovf;
      end
      // Signed less-than: sign of the difference corrected by overflow.
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, sub_sum[Msb] ^ sub_ovf};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic: FSM transitions, multiply iteration and result loading.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;

    case (state_q)
      StIdle: ;
      StBusy: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          // All multiplier bits consumed: publish the low half.
          result_d = mul_lo;
          zero_d   = (mul_lo == '0);
          neg_d    = mul_lo[Msb];
          carry_d  = |acc_q[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          state_d  = StDone;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Acceptance overrides the above; covers both IDLE and back-to-back DONE.
    if (accept) begin
      if (op == OpMul) begin
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = StBusy;
      end else begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        neg_d    = alu_res[Msb];
        carry_d  = alu_c;
        ovf_d    = alu_v;
        state_d  = StDone;
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8).
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic       zero, carry, overflow, negative;

  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .negative(negative)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an op, wait (bounded) for in_ready, let the edge accept it.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    op = o; a = x; b = y; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin cyc(); n++; end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid, bounded.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin cyc(); n++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({in_ready, out_valid, result, zero, carry, overflow, negative} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b res=%h flags=%b required all 0",
               in_ready, out_valid, result, {zero, carry, overflow, negative});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add();
    send(3'b010, 8'hFF, 8'h01);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_latency: out_valid=%b required 1", out_valid);
    end
    checks++;
    if ({result, zero, carry, overflow, negative} !== {8'h00, 4'b1100}) begin
      failures++;
      $display("FAIL add_ff_01: got res=%h zcvn=%b required res=00 zcvn=1100",
               result, {zero, carry, overflow, negative});
    end
  endtask

  task automatic test_sub();
    send(3'b011, 8'h80, 8'h01);
    checks++;
    if ({out_valid, result, zero, carry, overflow, negative} !== {1'b1, 8'h7F, 4'b0110}) begin
      failures++;
      $display("FAIL sub_80_01: got vld=%b res=%h zcvn=%b required vld=1 res=7f zcvn=0110",
               out_valid, result, {zero, carry, overflow, negative});
    end
    send(3'b011, 8'h01, 8'h02);
    checks++;
    if ({out_valid, result, zero, carry, overflow, negative} !== {1'b1, 8'hFF, 4'b0001}) begin
      failures++;
      $display("FAIL sub_01_02: got vld=%b res=%h zcvn=%b required vld=1 res=ff zcvn=0001",
               out_valid, result, {zero, carry, overflow, negative});
    end
  endtask

  task automatic test_slt_xor();
    send(3'b101, 8'h80, 8'h01);
    checks++;
    if ({result, zero, carry, overflow, negative} !== {8'h01, 4'b0000}) begin
      failures++;
      $display("FAIL slt_80_01: got res=%h zcvn=%b required res=01 zcvn=0000",
               result, {zero, carry, overflow, negative});
    end
    send(3'b101, 8'h01, 8'h80);
    checks++;
    if ({result, zero} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL slt_01_80: got res=%h z=%b required res=00 z=1", result, zero);
    end
    send(3'b111, 8'hFF, 8'hFF);
    checks++;
    if ({result, zero, carry, overflow, negative} !== {8'h00, 4'b1000}) begin
      failures++;
      $display("FAIL reserved_op: got res=%h zcvn=%b required res=00 zcvn=1000",
               result, {zero, carry, overflow, negative});
    end
  endtask

  task automatic test_mul();
    int n;
    send(3'b110, 8'h0F, 8'h11);
    wait_out(n);
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL mul_latency: got %0d cycles required 9", n);
    end
    checks++;
    if ({result, zero, carry, overflow, negative} !== {8'hFF, 4'b0001}) begin
      failures++;
      $display("FAIL mul_0f_11: got res=%h zcvn=%b required res=ff zcvn=0001",
               result, {zero, carry, overflow, negative});
    end
    cyc();
    send(3'b110, 8'h10, 8'h20);
    cyc();
    cyc();
    op = 3'b000; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    checks++;
    if ({in_ready, out_valid, result} !== {2'b00, 8'hFF}) begin
      failures++;
      $display("FAIL mul_busy_hold: got rdy=%b vld=%b res=%h required rdy=0 vld=0 res=ff",
               in_ready, out_valid, result);
    end
    cyc();
    in_valid = 1'b0;
    wait_out(n);
    checks++;
    if ({out_valid, result, zero, carry, overflow, negative} !== {1'b1, 8'h00, 4'b1100}) begin
      failures++;
      $display("FAIL mul_10_20: got vld=%b res=%h zcvn=%b required vld=1 res=00 zcvn=1100",
               out_valid, result, {zero, carry, overflow, negative});
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(3'b100, 8'hA5, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {2'b10, 8'hAA}) begin
        failures++;
        $display("FAIL xor_backpressure[%0d]: got vld=%b rdy=%b res=%h required vld=1 rdy=0 res=aa",
                 i, out_valid, in_ready, result);
      end
      cyc();
    end
    out_ready = 1'b1;
    op = 3'b001; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: got %b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, result} !== {1'b1, 8'h03}) begin
      failures++;
      $display("FAIL b2b_or: got vld=%b res=%h required vld=1 res=03", out_valid, result);
    end
  endtask

  task automatic test_reset_mid_mul();
    send(3'b110, 8'h0F, 8'h11);
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, result, zero} !== 11'h0) begin
      failures++;
      $display("FAIL mid_reset: got vld=%b rdy=%b res=%h z=%b required all 0",
               out_valid, in_ready, result, zero);
    end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset_release: got rdy=%b vld=%b required rdy=1 vld=0",
               in_ready, out_valid);
    end
    send(3'b000, 8'hF0, 8'h3C);
    checks++;
    if ({out_valid, result, zero, carry, overflow, negative} !== {1'b1, 8'h30, 4'b0000}) begin
      failures++;
      $display("FAIL and_after_reset: got vld=%b res=%h zcvn=%b required vld=1 res=30 zcvn=0000",
               out_valid, result, {zero, carry, overflow, negative});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt_xor();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
